read_channel_axi_burst: RTL
===========================

Name: read_channel_axi_burst

Overview:
- Next-generation cache line-refill read engine on the AXI4 master read channel.
- Fetches one cache line of 2**LINE2MEM_W backend words as one or more INCR bursts; the line is split when it exceeds the maximum burst length.
- Streams each beat to the cache data memory.
- On slave/protocol errors, retries the whole line a bounded number of times, then reports failure.
- Sits between the cache control FSM (replace request) and the backend AXI interconnect.

Parameters:
- FE_ADDR_W, 32, frontend byte-address width.
- BE_ADDR_W, FE_ADDR_W, backend/AXI address width.
- BE_DATA_W, 32, backend/AXI data width. BE_BYTE_W = log2(BE_DATA_W/8).
- LINE2MEM_W, 2, log2(backend words per line); 0 is legal (single beat).
- MAX_BURST_W, 8, log2 of the maximum beats per burst. BURST_W = min(LINE2MEM_W, MAX_BURST_W).
- MAX_RETRY, 3, line re-fetches allowed after an error; 0 means no retry.
- AXI_LEN_W, 8, width of arlen.
- AXI_ID_W, 1, AXI ID width.
- AXI_ID, 0, ID driven on arid and expected on rid.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- replace_valid  in  1  line refill request; sampled only in IDLE.
- replace_addr  in  FE_ADDR_W-BE_BYTE_W-LINE2MEM_W  line address.
- replace  out  1  engine busy (high in every state except IDLE).
- read_valid  out  1  beat write strobe to the line memory.
- read_addr  out  max(LINE2MEM_W,1)  word index within the line.
- read_rdata  out  BE_DATA_W  beat data, equal to m_axi_rdata.
- error  out  1  one-cycle pulse: line failed after the retries were exhausted.
- m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  AXI_ID_W/BE_ADDR_W/AXI_LEN_W/3/2/1/4/3/1  AR channel.
- m_axi_arready  in  1.
- m_axi_rid/rdata/rresp/rlast/rvalid  in  AXI_ID_W/BE_DATA_W/2/1/1  R channel.
- m_axi_rready  out  1.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, burst_idx=0, beat_cnt=0, read_addr=0, err_flag=0, retry_cnt=0. Outputs replace, arvalid, rready, read_valid and error are all 0. Reset during any state aborts the transfer; the next cycle is IDLE with arvalid=0.
- Constant AR fields: arid=AXI_ID, arsize=BE_BYTE_W, arburst=2'b01, arlock=0, arcache=4'b0011, arprot=0.
- arlen = 2**BURST_W-1, zero-extended to AXI_LEN_W.
- araddr = {replace_addr, LINE2MEM_W+BE_BYTE_W zeros} + burst_idx*(2**BURST_W)*(BE_DATA_W/8), zero-extended to BE_ADDR_W.
- Number of bursts per line: NBURST = 2**(LINE2MEM_W-BURST_W).
- IDLE: replace=0, read_addr=0. If replace_valid, latch replace_addr, clear err_flag and retry_cnt, set burst_idx=0, go to ADDR. Total latency from request to arvalid is 1 cycle.
- ADDR: arvalid=1, with araddr and arlen held stable until arready. On arready, beat_cnt=0 and go to DATA.
- DATA: rready=1; read_valid = m_axi_rvalid.
- On each rvalid beat:
  - err_flag is set if rresp!=0, or rid!=AXI_ID, or rlast is set on a beat other than the 2**BURST_W-th, or rlast is clear on that beat.
  - read_addr increments, wrapping mod 2**LINE2MEM_W (held at 0 when LINE2MEM_W=0).
  - beat_cnt increments.
- The burst ends on beat 2**BURST_W; early rlast does not end it. Then:
  - if burst_idx<NBURST-1: burst_idx++, go to ADDR;
  - otherwise go to DONE.
- DONE (1 cycle, covers memory write latency):
  - err_flag=0: go to IDLE.
  - err_flag=1 and retry_cnt<MAX_RETRY: retry_cnt++, clear err_flag, set burst_idx=0 and read_addr=0, go to ADDR.
  - err_flag=1 and retry_cnt==MAX_RETRY: error=1 for this cycle only, then go to IDLE.
- replace_valid is ignored outside IDLE.
- rvalid arriving in IDLE or ADDR is not accepted (rready=0).
- arvalid and rready are never high in the same cycle.

Test Plan:
- Single burst: LINE2MEM_W=2, MAX_BURST_W=8, replace_addr→byte 0x100, beats D0..D3 with rresp=0 → one AR (araddr=0x100, arlen=3); read_addr 0,1,2,3 with matching data; replace falls 1 cycle after DONE; error=0.
- Split line: MAX_BURST_W=1, line byte 0x1000 → AR 0x1000 arlen=1, then AR 0x1008 arlen=1; read_addr runs 0..3 continuously.
- AR backpressure and R gaps: arready held low 5 cycles and rvalid toggled → araddr/arlen stay stable while arvalid=1; read_valid only on rvalid beats; all 4 words written.
- Retry recovery: rresp=2'b10 on beat 2 of the first attempt, clean second attempt → two full ARs to the same address; read_addr restarts at 0; error stays 0.
- Retry exhaustion: MAX_RETRY=1, rresp=SLVERR on every attempt → exactly 2 ARs; error pulses for 1 cycle in DONE; IDLE next cycle.
- LINE2MEM_W=0, plus a reset asserted mid-DATA → arlen=0, one beat at read_addr=0; on reset mid-DATA, IDLE next cycle with rready=0, replace=0 and error=0.

Source files
------------

// File: rtl/read_channel_axi_burst.sv
// read_channel_axi_burst
//   Cache line-refill engine on the AXI4 read channel. It fetches one line of
//   2**LINE2MEM_W backend words as one or more INCR bursts of 2**BURST_W
//   beats and streams every beat to the line memory. A line that sees any
//   protocol or slave error is fetched again, up to MAX_RETRY times. If it
//   still fails, a one-cycle error pulse is raised.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   replace_valid/_addr   refill request and line address (taken only in IDLE)
//   replace               engine busy
//   read_valid/_addr/_rdata  beat write port to the line memory
//   error                 line failed after all retries
//   m_axi_ar*/m_axi_r*    AXI4 master read address and read data channels
module read_channel_axi_burst #(
  parameter int FE_ADDR_W   = 32,
  parameter int BE_ADDR_W   = FE_ADDR_W,
  parameter int BE_DATA_W   = 32,
  parameter int LINE2MEM_W  = 2,
  parameter int MAX_BURST_W = 8,
  parameter int MAX_RETRY   = 3,
  parameter int AXI_LEN_W   = 8,
  parameter int AXI_ID_W    = 1,
  parameter int AXI_ID      = 0,
  localparam int BE_BYTE_W  = $clog2(BE_DATA_W/8),
  localparam int LA_W       = FE_ADDR_W-BE_BYTE_W-LINE2MEM_W,
  localparam int RA_W       = (LINE2MEM_W > 0) ? LINE2MEM_W : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 replace_valid,
  input  logic [LA_W-1:0]      replace_addr,
  output logic                 replace,
  output logic                 read_valid,
  output logic [RA_W-1:0]      read_addr,
  output logic [BE_DATA_W-1:0] read_rdata,
  output logic                 error,
  output logic [AXI_ID_W-1:0]  m_axi_arid,
  output logic [BE_ADDR_W-1:0] m_axi_araddr,
  output logic [AXI_LEN_W-1:0] m_axi_arlen,
  output logic [2:0]           m_axi_arsize,
  output logic [1:0]           m_axi_arburst,
  output logic                 m_axi_arlock,
  output logic [3:0]           m_axi_arcache,
  output logic [2:0]           m_axi_arprot,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [AXI_ID_W-1:0]  m_axi_rid,
  input  logic [BE_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rlast,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready
);

  localparam int BURST_W  = (LINE2MEM_W < MAX_BURST_W) ? LINE2MEM_W : MAX_BURST_W;
  localparam int NBURST_W = LINE2MEM_W - BURST_W;
  localparam int NBURST   = 2**NBURST_W;
  localparam int BEATS    = 2**BURST_W;
  localparam int BI_W     = (NBURST_W > 0) ? NBURST_W : 1;
  localparam int BC_W     = BURST_W + 1;
  localparam int RT_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;

  localparam logic [BI_W-1:0]      BI_LAST   = BI_W'(NBURST-1);
  localparam logic [BC_W-1:0]      BC_LAST   = BC_W'(BEATS-1);
  localparam logic [RT_W-1:0]      RT_MAX    = RT_W'(MAX_RETRY);
  localparam logic [AXI_LEN_W-1:0] ARLEN     = AXI_LEN_W'(BEATS-1);
  localparam logic [AXI_ID_W-1:0]  ID        = AXI_ID_W'(AXI_ID);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [LA_W-1:0] line_addr_q, line_addr_d;
  logic [BI_W-1:0] burst_idx_q, burst_idx_d;
  logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [RA_W-1:0] read_addr_q, read_addr_d;
  logic            err_flag_q, err_flag_d;
  logic [RT_W-1:0] retry_cnt_q, retry_cnt_d;

  logic            last_beat;
  logic            beat_err;
  logic [BE_ADDR_W-1:0] base_addr, burst_off;

  // The burst is closed by the beat count alone; rlast is only cross-checked.
  assign last_beat = (beat_cnt_q == BC_LAST);
  assign beat_err  = (m_axi_rresp != 2'b00) || (m_axi_rid != ID) ||
                     (m_axi_rlast != last_beat);

  assign base_addr = BE_ADDR_W'(line_addr_q) << (LINE2MEM_W + BE_BYTE_W);
  assign burst_off = BE_ADDR_W'(burst_idx_q) << (BURST_W + BE_BYTE_W);

  always_comb begin
    state_d     = state_q;
    line_addr_d = line_addr_q;
    burst_idx_d = burst_idx_q;
    beat_cnt_d  = beat_cnt_q;
    read_addr_d = read_addr_q;
    err_flag_d  = err_flag_q;
    retry_cnt_d = retry_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (replace_valid) begin
          line_addr_d = replace_addr;
          err_flag_d  = 1'b0;
          retry_cnt_d = '0;
          burst_idx_d = '0;
          read_addr_d = '0;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axi_arready) begin
          beat_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (m_axi_rvalid) begin
          if (beat_err) err_flag_d = 1'b1;
          if (LINE2MEM_W > 0) read_addr_d = read_addr_q + 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            if (burst_idx_q != BI_LAST) begin
              burst_idx_d = burst_idx_q + 1'b1;
              state_d     = S_ADDR;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        // One idle cycle lets the last beat settle in the line memory.
        if (!err_flag_q) begin
          state_d = S_IDLE;
        end else if (retry_cnt_q != RT_MAX) begin
          retry_cnt_d = retry_cnt_q + 1'b1;
          err_flag_d  = 1'b0;
          burst_idx_d = '0;
          read_addr_d = '0;
          state_d     = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      line_addr_q <= '0;
      burst_idx_q <= '0;
      beat_cnt_q  <= '0;
      read_addr_q <= '0;
      err_flag_q  <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      burst_idx_q <= burst_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      read_addr_q <= read_addr_d;
      err_flag_q  <= err_flag_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign replace       = (state_q != S_IDLE);
  assign m_axi_arvalid = (state_q == S_ADDR);
  assign m_axi_rready  = (state_q == S_DATA);
  assign read_valid    = (state_q == S_DATA) && m_axi_rvalid;
  assign read_addr     = (state_q == S_IDLE) ? '0 : read_addr_q;
  assign read_rdata    = m_axi_rdata;
  assign error         = (state_q == S_DONE) && err_flag_q && (retry_cnt_q == RT_MAX);

  assign m_axi_arid    = ID;
  assign m_axi_araddr  = base_addr + burst_off;
  assign m_axi_arlen   = ARLEN;
  assign m_axi_arsize  = 3'(BE_BYTE_W);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;

endmodule
